// File: rtl/reduce_gate_unit.sv
// reduce_gate_unit
//
// Registered, flow-controlled reduction gate. Each accepted beat of WIDTH
// bits is reduced to a single bit under a selectable logic mode; the result
// is presented together with the population count of the reduced bits.
// With NOR mode and WIDTH=4 it behaves as the legacy 4-input NOR gate,
// registered.
//
// Build option:
//   REDUCE_GATE_ACC_EN  when defined, one reduction may span a multi-beat
//                       frame terminated by in_last. When undefined, every
//                       accepted beat is a complete frame and in_last is
//                       ignored.
//
// Parameters:
//   WIDTH  bits reduced per beat (>= 2)
//   CNT_W  width of the saturating ones/bits counters (must hold WIDTH)
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   in_valid   input beat offered
//   in_ready   unit can accept a beat this cycle (!out_valid || out_ready)
//   in_data    bits to reduce
//   in_mode    000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR,
//              110 MAJ, 111 reserved (sampled on the first beat of a frame)
//   in_last    final beat of frame (accumulating build only)
//   out_valid  result held
//   out_ready  sink accepts result
//   out_y      reduction result
//   out_ones   saturating count of 1 bits in the reduced beat/frame
//   out_err    reserved mode was used
//
// States:
//   IDLE | no frame in progress, no result held
//   ACC  | frame open, folding beats into the accumulators (accumulating build)
//   HOLD | result presented on out_*, waiting for out_ready

module reduce_gate_unit #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [2:0]       in_mode,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_y,
  output logic [CNT_W-1:0] out_ones,
  output logic             out_err
);

  localparam logic [CNT_W-1:0] BEAT_BITS = CNT_W'(WIDTH);

  localparam logic [2:0] MODE_AND  = 3'b000;
  localparam logic [2:0] MODE_OR   = 3'b001;
  localparam logic [2:0] MODE_XOR  = 3'b010;
  localparam logic [2:0] MODE_NAND = 3'b011;
  localparam logic [2:0] MODE_NOR  = 3'b100;
  localparam logic [2:0] MODE_XNOR = 3'b101;
  localparam logic [2:0] MODE_MAJ  = 3'b110;

`ifdef REDUCE_GATE_ACC_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd2
  } state_t;
`endif

  function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] d);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      c = c + CNT_W'(d[i]);
    end
    return c;
  endfunction

  // Saturating add: the counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  state_t state_q, state_d;

  logic             accept;
  logic             frame_end;
  logic             present;

  logic             b_and, b_or, b_xor;
  logic [CNT_W-1:0] b_ones;

  // Frame terms including the current beat: what the accumulators become
  // on acceptance and what the result is computed from at frame end.
  logic [2:0]       res_mode;
  logic             res_and, res_or, res_xor;
  logic [CNT_W-1:0] res_ones, res_bits;
  logic             res_maj;
  logic             res_y, res_err;

  assign out_valid = (state_q == HOLD);
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;

  assign b_and  = &in_data;
  assign b_or   = |in_data;
  assign b_xor  = ^in_data;
  assign b_ones = popcount(in_data);

`ifdef REDUCE_GATE_ACC_EN
  logic [2:0]       mode_q;
  logic             and_q, or_q, xor_q;
  logic [CNT_W-1:0] ones_q, bits_q;

  assign frame_end = in_last;

  always_comb begin
    res_mode = in_mode;
    res_and  = b_and;
    res_or   = b_or;
    res_xor  = b_xor;
    res_ones = b_ones;
    res_bits = BEAT_BITS;
    if (state_q == ACC) begin
      // Mode was captured on the frame's first beat; later in_mode is ignored.
      res_mode = mode_q;
      res_and  = and_q & b_and;
      res_or   = or_q | b_or;
      res_xor  = xor_q ^ b_xor;
      res_ones = sat_add(ones_q, b_ones);
      res_bits = sat_add(bits_q, BEAT_BITS);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q <= 3'b000;
      and_q  <= 1'b0;
      or_q   <= 1'b0;
      xor_q  <= 1'b0;
      ones_q <= '0;
      bits_q <= '0;
    end else if (accept) begin
      mode_q <= res_mode;
      and_q  <= res_and;
      or_q   <= res_or;
      xor_q  <= res_xor;
      ones_q <= res_ones;
      bits_q <= res_bits;
    end
  end
`else
  logic unused_last;

  assign unused_last = in_last;
  assign frame_end   = 1'b1;

  always_comb begin
    res_mode = in_mode;
    res_and  = b_and;
    res_or   = b_or;
    res_xor  = b_xor;
    res_ones = b_ones;
    res_bits = BEAT_BITS;
  end
`endif

  // Majority uses the saturated counters; a tie gives 0.
  assign res_maj = ({1'b0, res_ones, 1'b0} > {2'b00, res_bits});

  always_comb begin
    res_y   = 1'b0;
    res_err = 1'b0;
    case (res_mode)
      MODE_AND:  res_y = res_and;
      MODE_OR:   res_y = res_or;
      MODE_XOR:  res_y = res_xor;
      MODE_NAND: res_y = !res_and;
      MODE_NOR:  res_y = !res_or;
      MODE_XNOR: res_y = !res_xor;
      MODE_MAJ:  res_y = res_maj;
      default:   res_err = 1'b1;
    endcase
  end

  // A beat can only be accepted in HOLD when out_ready is high, so a held
  // result is never overwritten while the sink is stalling.
  always_comb begin
    state_d = state_q;
    present = 1'b0;
    if (accept) begin
      if (frame_end) begin
        state_d = HOLD;
        present = 1'b1;
      end else begin
`ifdef REDUCE_GATE_ACC_EN
        state_d = ACC;
`else
        state_d = HOLD;
`endif
      end
    end else if (state_q == HOLD && out_ready) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      out_y    <= 1'b0;
      out_ones <= '0;
      out_err  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (present) begin
        out_y    <= res_y;
        out_ones <= res_ones;
        out_err  <= res_err;
      end
    end
  end

endmodule

// File: doc/reduce_gate_unit.md
# reduce_gate_unit

Parametrised, registered successor to the fixed 4-input NOR gate. It reduces a WIDTH-bit input vector to one bit under a selectable logic mode and reports the population count alongside the result. A valid/ready handshake sits on both sides. Optionally, one reduction can span a multi-beat frame. It sits between lab stimulus logic (switch/FSM sources) and LED or downstream-control sinks that need a registered, flow-controlled gate result.

## Interface
- WIDTH, 4, number of input bits reduced per beat (>= 2)
- CNT_W, 8, width of the ones/bit counters (must hold WIDTH)

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  input beat offered
- in_ready  out  1  unit can accept a beat this cycle
- in_data  in  WIDTH  bits to reduce
- in_mode  in  3  000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 110 MAJ, 111 reserved
- in_last  in  1  final beat of frame (used only with accumulation compiled in)
- out_valid  out  1  result held
- out_ready  in  1  sink accepts result
- out_y  out  1  reduction result
- out_ones  out  CNT_W  count of 1 bits in the reduced beat/frame, saturating
- out_err  out  1  reserved mode was used

## Operation
- Beat accepted when in_valid && in_ready; in_ready = !out_valid || out_ready (combinational).
- Per-beat terms: and_b = &in_data, or_b = |in_data, xor_b = ^in_data, ones_b = popcount(in_data).
- Modes: NAND/NOR/XNOR are the inversions of AND/OR/XOR. MAJ gives 1 iff 2*ones > total bits (ties give 0). Reserved mode gives out_y=0 and out_err=1.
- NOR mode with WIDTH=4 reproduces the legacy gate exactly, registered.
- State machine: IDLE, ACC, HOLD.
  - IDLE: an accepted beat latches mode, then goes to HOLD (non-ACC build, or in_last=1) or to ACC.
  - ACC: accepted beats fold into the accumulators (AND &=, OR |=, XOR ^=, ones +=, bits += WIDTH). A beat with in_last=1 goes to HOLD.
  - HOLD: out_valid=1. On out_ready, goes to IDLE, or directly takes a new accepted beat in the same cycle (back-to-back).
- Mode is sampled on the first beat of a frame only; in_mode on later beats is ignored.
- Counters (ones, bits) saturate at 2^CNT_W-1 and never wrap. MAJ uses the saturated values.
- out_y, out_ones and out_err are stable while out_valid=1 && out_ready=0.

## Timing
- Reset values: out_valid=0, out_y=0, out_ones=0, out_err=0, state=IDLE, accumulators cleared. After reset, in_ready=1.
- Latency: out_valid rises the cycle after the accepting edge of the final (or only) beat.
- Throughput: one result per cycle when out_ready is held at 1.
- Simultaneous out_ready and new in_valid in HOLD: the old result retires and the new one is presented next cycle, with no bubble.
- Reset asserted mid-frame or during HOLD: the partial frame and the held result are discarded, with no output on the following cycle.
- in_valid deasserted mid-frame: the accumulators hold; there is no timeout.

## Configuration
- REDUCE_GATE_ACC_EN defined: multi-beat frames are supported. The ACC state and the frame accumulators are built, and in_last is honoured.
- Not defined: every accepted beat is a complete frame. in_last is ignored, ACC does not exist, and out_ones is the per-beat popcount (zero-extended).

## Test plan
- Reset, then WIDTH=4, mode NOR, in_data=4'b0000 → next cycle out_valid=1, out_y=1, out_ones=0. Then in_data=4'b0100 → out_y=0, out_ones=1.
- Sweep all 16 values × modes 000–110 with out_ready=1 → out_y matches the per-mode golden model every cycle. Mode 111 → out_y=0, out_err=1.
- Backpressure: out_ready=0 for 5 cycles with in_valid=1 → in_ready=0, and the outputs stay stable. Then out_ready=1 → one result retires and the next is accepted in the same cycle.
- (ACC_EN) Frame of 3 beats, mode AND: 1111, 1111, 1011 with last on beat 3 → out_y=0, out_ones=11. Mode changed on beat 2 is ignored.
- (ACC_EN) MAJ frame 1100, 0011 → ones=4, bits=8 → tie → out_y=0. Then 1110, 0011 → out_y=1.
- Reset pulse after beat 2 of a 3-beat frame → out_valid=0. The next single-beat frame 0000 in NOR mode → out_y=1, out_ones=0, with no residue from the aborted frame.
